// File: rtl/uart_boot_loader.sv
// uart_boot_loader: 8N1 UART receiver that loads a little-endian program image into instruction memory, then releases the CPU.
// Optional feature macro CHECKSUM_EN: an XOR checksum byte follows the data, and a mismatch sends the loader to ERR.
module uart_boot_loader #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CPB / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CHK, S_RUN, S_ERR} state_t;
    localparam state_t S_TAIL = S_CHK;
`else
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_RUN, S_ERR} state_t;
    localparam state_t S_TAIL = S_RUN;
`endif

    rx_state_t         r_rx_st, w_rx_nx;
    logic [2:0]        r_sync;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_bv, r_fe;
    logic              w_rx, w_fall, w_tick;

    state_t            r_st, w_st_nx;
    logic [7:0]        r_n_lo;
    logic [ADDR_W:0]   r_n, r_widx;
    logic [31:0]       r_word, r_wdata;
    logic [1:0]        r_bcnt;
    logic              r_we, w_wr, w_in_chk;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       w_n;
    logic [7:0]        w_byte;
`ifdef CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    assign w_rx   = r_sync[1];
    assign w_fall = r_sync[2] & ~r_sync[1];
    assign w_tick = r_cnt == C_FULL;
    assign w_byte = r_shift;
    assign w_n    = {w_byte, r_n_lo};

    // Receiver state register
    always_ff @(posedge clk) begin
        if (areset) r_rx_st <= RX_IDLE;
        else        r_rx_st <= w_rx_nx;
    end

    // Receiver next state: start is re-checked at half a bit, data and stop sampled at bit centres
    always_comb begin
        w_rx_nx = r_rx_st;
        case (r_rx_st)
            RX_IDLE:  w_rx_nx = w_fall ? RX_START : RX_IDLE;
            RX_START: w_rx_nx = (r_cnt == C_HALF) ? (w_rx ? RX_IDLE : RX_DATA) : RX_START;
            RX_DATA:  w_rx_nx = (w_tick && r_bit == 3'd7) ? RX_STOP : RX_DATA;
            default:  w_rx_nx = w_tick ? RX_IDLE : RX_STOP;
        endcase
    end

    // Receiver datapath: synchroniser, bit timer, LSB-first shifter, byte/framing-error pulses
    always_ff @(posedge clk) begin
        if (areset) begin
            r_sync  <= 3'b111;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_bv    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[1:0], rx};
            r_cnt   <= (r_rx_st == RX_IDLE || w_rx_nx != r_rx_st || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit   <= (r_rx_st == RX_DATA) ? r_bit + {2'b00, w_tick} : 3'd0;
            if (r_rx_st == RX_DATA && w_tick) r_shift <= {w_rx, r_shift[7:1]};
            r_bv    <= r_rx_st == RX_STOP && w_tick && w_rx;
            r_fe    <= r_rx_st == RX_STOP && w_tick && !w_rx;
        end
    end

    // Load-control state register
    always_ff @(posedge clk) begin
        if (areset) r_st <= S_HDR0;
        else        r_st <= w_st_nx;
    end

    // Load-control next state; the run release waits one cycle past the final write strobe
    always_comb begin
        w_st_nx = r_st;
        w_wr    = 1'b0;
        if (r_fe && r_st != S_RUN && r_st != S_ERR) w_st_nx = S_ERR;
        else case (r_st)
            S_HDR0: w_st_nx = r_bv ? S_HDR1 : S_HDR0;
            S_HDR1: if (r_bv) w_st_nx = (w_n == 16'd0) ? S_TAIL : (32'(w_n) > 32'(MAX_WORDS)) ? S_ERR : S_DATA;
            S_DATA: begin
                w_wr    = r_bv && r_bcnt == 2'd3;
                w_st_nx = (r_we && r_widx == r_n) ? S_TAIL : S_DATA;
            end
`ifdef CHECKSUM_EN
            S_CHK:  if (r_bv) w_st_nx = (w_byte == r_csum) ? S_RUN : S_ERR;
`endif
            default: w_st_nx = r_st;
        endcase
    end

    // Header latch, byte packer and write-port registers
    always_ff @(posedge clk) begin
        if (areset) begin
            r_n_lo  <= 8'd0;
            r_n     <= '0;
            r_word  <= 32'd0;
            r_bcnt  <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_widx  <= '0;
        end else begin
            if (r_st == S_HDR0 && r_bv) r_n_lo <= w_byte;
            if (r_st == S_HDR1 && r_bv) r_n <= w_n[ADDR_W:0];
            if (r_st == S_DATA && r_bv) begin
                r_word <= {w_byte, r_word[31:8]};
                r_bcnt <= r_bcnt + 2'd1;
            end
            r_we <= w_wr;
            if (w_wr) begin
                r_addr  <= r_widx[ADDR_W-1:0];
                r_wdata <= {w_byte, r_word[31:8]};
                r_widx  <= r_widx + 1'b1;
            end
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR of every data byte
    always_ff @(posedge clk) begin
        if (areset)                 r_csum <= 8'd0;
        else if (r_st == S_DATA && r_bv) r_csum <= r_csum ^ w_byte;
    end
    assign w_in_chk = r_st == S_CHK;
`else
    assign w_in_chk = 1'b0;
`endif

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_widx;
    assign cpu_run      = r_st == S_RUN;
    assign err          = r_st == S_ERR;
    assign busy         = r_st == S_HDR1 || r_st == S_DATA || w_in_chk;
endmodule
